// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: 16x oversampling, two-flop synchronizer, 3-sample majority vote,
// start-glitch rejection, framing-error strobe and line-break hold-off.
module uart_rx_oversampled #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned DIV      = (CLK_FREQ + BAUD * 8) / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rxReady,
  output logic [7:0] rxData,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q, state_d;
  logic            rx_s1_q, rx_s2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      ph_q, ph_d;
  logic [1:0]      samp_q, samp_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [3:0]      brk_q, brk_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_ready_q, rx_ready_d;
  logic            frame_error_q, frame_error_d;
  logic            busy_q, busy_d;

  logic tick, vote_valid, vote;

  assign tick       = (cnt_q == CntMax);
  assign vote_valid = tick && (ph_q == 4'd9);
  // Samples taken at ph 7 and 8 plus the live sample at ph 9.
  assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q) | (samp_q[1] & rx_s2_q);

  always_comb begin
    state_d       = state_q;
    cnt_d         = tick ? '0 : cnt_q + CntW'(1);
    ph_d          = ph_q;
    samp_d        = samp_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    brk_d         = brk_q;
    rx_data_d     = rx_data_q;
    rx_ready_d    = 1'b0;
    frame_error_d = 1'b0;

    if (tick) begin
      ph_d = ph_q + 4'd1;
      if (ph_q == 4'd7) samp_d[0] = rx_s2_q;
      if (ph_q == 4'd8) samp_d[1] = rx_s2_q;
    end

    unique case (state_q)
      StIdle: begin
        if (!rx_s2_q) begin
          // Restart the bit timing from the falling edge.
          state_d = StStart;
          cnt_d   = '0;
          ph_d    = '0;
        end
      end
      StStart: begin
        if (vote_valid) begin
          if (vote) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_idx_d = '0;
          end
        end
      end
      StData: begin
        if (vote_valid) begin
          shift_d = {vote, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = StStop;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      StStop: begin
        if (vote_valid) begin
          if (vote) begin
            rx_data_d  = shift_q;
            rx_ready_d = 1'b1;
            state_d    = StIdle;
          end else begin
            frame_error_d = 1'b1;
            brk_d         = '0;
            state_d       = StBreak;
          end
        end
      end
      StBreak: begin
        // Leave only after 16 consecutive high ticks on the line.
        if (tick) begin
          if (rx_s2_q) begin
            if (brk_q == 4'd15) begin
              brk_d   = '0;
              state_d = StIdle;
            end else begin
              brk_d = brk_q + 4'd1;
            end
          end else begin
            brk_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      cnt_q         <= '0;
      ph_q          <= '0;
      samp_q        <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      brk_q         <= '0;
      rx_data_q     <= '0;
      rx_ready_q    <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_s1_q       <= rx;
      rx_s2_q       <= rx_s1_q;
      cnt_q         <= cnt_d;
      ph_q          <= ph_d;
      samp_q        <= samp_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      brk_q         <= brk_d;
      rx_data_q     <= rx_data_d;
      rx_ready_q    <= rx_ready_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

  assign rxReady     = rx_ready_q;
  assign rxData      = rx_data_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed plus randomized bench for uart_rx_oversampled at default parameters (432 clocks/bit).
module tb_uart_rx_oversampled;

  localparam int BitClks = 432;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rxReady;
  logic [7:0] rxData;
  logic       frame_error;
  logic       busy;

  uart_rx_oversampled dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rxReady    (rxReady),
    .rxData     (rxData),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: append-only record of what the DUT emitted.
  logic [7:0]  got_q[$];
  int unsigned rdy_cyc_q[$];
  int unsigned fe_cnt    = 0;
  int unsigned both_cnt  = 0;
  int unsigned busy_cyc  = 0;

  always @(negedge clk) begin
    if (rxReady) begin
      got_q.push_back(rxData);
      rdy_cyc_q.push_back(cyc);
    end
    if (frame_error) fe_cnt++;
    if (rxReady && frame_error) both_cnt++;
    if (busy) busy_cyc++;
  end

  // Reference model: every frame sent with a high stop bit yields its byte, in order.
  logic [7:0] exp_q[$];
  int         rd_idx  = 0;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v, input int clks);
    rx = v;
    wait_clks(clks);
  endtask

  task automatic send_byte(input logic [7:0] b, input int clks, input logic stop);
    send_bit(1'b0, clks);
    for (int i = 0; i < 8; i++) send_bit(b[i], clks);
    send_bit(stop, clks);
    if (stop) exp_q.push_back(b);
  endtask

  task automatic check_rx(input string tag);
    int n_got;
    n_got = got_q.size() - rd_idx;
    chk({tag, "_count"}, n_got, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_got; i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'h0, got_q[rd_idx+i]}, {24'h0, exp_q[i]});
    rd_idx = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    int unsigned t0, c1, c2, bc0, fe0, n_rdy;
    int          per;
    logic [7:0]  b;

    reset = 1'b1;
    rx    = 1'b1;
    wait_clks(5);
    chk("reset_rxReady", rxReady, 0);
    chk("reset_rxData", rxData, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_error", frame_error, 0);
    reset = 1'b0;

    // Idle line.
    wait_clks(10000);
    chk("idle_strobes", got_q.size(), 0);
    chk("idle_fe", fe_cnt, 0);
    chk("idle_busy", busy_cyc, 0);
    chk("idle_rxData", rxData, 0);

    // Back-to-back 0x0A, 0x00 with latency and spacing checks.
    n_rdy = rdy_cyc_q.size();
    t0    = cyc;
    send_byte(8'h0A, BitClks, 1'b1);
    send_byte(8'h00, BitClks, 1'b1);
    wait_clks(50);
    c1 = (rdy_cyc_q.size() > n_rdy)     ? rdy_cyc_q[n_rdy]     : 0;
    c2 = (rdy_cyc_q.size() > n_rdy + 1) ? rdy_cyc_q[n_rdy + 1] : 0;
    chk("latency_first", ((c1 - t0) >= 4159) && ((c1 - t0) <= 4163), 1);
    chk("gap_second", ((c2 - c1) >= 4320 - 27) && ((c2 - c1) <= 4320 + 27), 1);
    check_rx("b2b");

    // Baud mismatch, fast then slow sender.
    send_byte(8'h55, 419, 1'b1);
    send_byte(8'hFF, 419, 1'b1);
    send_byte(8'h80, 419, 1'b1);
    wait_clks(50);
    check_rx("fast3pct");
    send_byte(8'h55, 445, 1'b1);
    send_byte(8'hFF, 445, 1'b1);
    send_byte(8'h80, 445, 1'b1);
    wait_clks(50);
    check_rx("slow3pct");

    // Start-bit glitch.
    bc0 = busy_cyc;
    fe0 = fe_cnt;
    send_bit(1'b0, 150);
    send_bit(1'b1, 400);
    chk("glitch_busy_pulsed", busy_cyc > bc0, 1);
    chk("glitch_busy_now", busy, 0);
    chk("glitch_fe", fe_cnt - fe0, 0);
    check_rx("glitch");
    send_byte(8'h07, BitClks, 1'b1);
    wait_clks(50);
    check_rx("after_glitch");

    // Framing error followed by a line break.
    fe0 = fe_cnt;
    send_byte(8'hA5, BitClks, 1'b0);
    send_bit(1'b0, 2000);
    chk("ferr_once", fe_cnt - fe0, 1);
    chk("break_busy_low", busy, 1);
    send_bit(1'b1, 300);
    chk("break_busy_early", busy, 1);
    wait_clks(200);
    chk("break_busy_done", busy, 0);
    chk("ferr_rxData_held", rxData, 8'h07);
    check_rx("ferr");
    send_byte(8'h3C, BitClks, 1'b1);
    wait_clks(50);
    check_rx("after_break");

    // Reset in the middle of data bit 4 of 0xC3.
    b = 8'hC3;
    send_bit(1'b0, BitClks);
    for (int i = 0; i < 4; i++) send_bit(b[i], BitClks);
    send_bit(b[4], BitClks / 2);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_rxData", rxData, 0);
    chk("mid_reset_rxReady", rxReady, 0);
    chk("mid_reset_fe", frame_error, 0);
    rx = 1'b1;
    wait_clks(5);
    reset = 1'b0;
    wait_clks(500);
    check_rx("mid_reset");
    send_byte(8'hC3, BitClks, 1'b1);
    wait_clks(50);
    check_rx("after_reset");

    // Random bytes at random rates inside the tolerance window.
    for (int i = 0; i < 3; i++) begin
      b   = 8'($urandom);
      per = int'($urandom_range(445, 419));
      send_byte(b, per, 1'b1);
    end
    wait_clks(50);
    check_rx("random");
    chk("final_rxData", rxData, got_q.size() > 0 ? {24'h0, got_q[got_q.size()-1]} : 32'hFFFF);
    chk("never_both", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
